// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 accelerator front end.
package sha256_pkg;
  localparam int ID_W            = 6;
  localparam int MAX_OUTSTANDING = 8;

  typedef logic [ID_W-1:0] id_t;

  typedef struct packed {
    logic [63:0] size;
    logic [1:0]  scheme;
    logic        last;
  } cfg_t;
endpackage

// File: rtl/sha256_id_issue_if.sv
// Configuration input, tagged configuration output and ID output streams.
interface sha256_id_issue_if;
  import sha256_pkg::*;

  logic [63:0] cfg_in_size;
  logic [1:0]  cfg_in_scheme;
  logic        cfg_in_last;
  logic        cfg_in_valid;
  logic        cfg_in_ready;

  logic [63:0] cfg_out_size;
  logic [1:0]  cfg_out_scheme;
  id_t         cfg_out_id;
  logic        cfg_out_last;
  logic        cfg_out_valid;
  logic        cfg_out_ready;

  id_t         id_out;
  logic        id_out_last;
  logic        id_out_valid;
  logic        id_out_ready;

  modport slave (
    input  cfg_in_size, cfg_in_scheme, cfg_in_last, cfg_in_valid,
    output cfg_in_ready,
    output cfg_out_size, cfg_out_scheme, cfg_out_id, cfg_out_last, cfg_out_valid,
    input  cfg_out_ready,
    output id_out, id_out_last, id_out_valid,
    input  id_out_ready
  );

  modport master (
    output cfg_in_size, cfg_in_scheme, cfg_in_last, cfg_in_valid,
    input  cfg_in_ready,
    input  cfg_out_size, cfg_out_scheme, cfg_out_id, cfg_out_last, cfg_out_valid,
    output cfg_out_ready,
    input  id_out, id_out_last, id_out_valid,
    output id_out_ready
  );
endinterface

// File: rtl/sha256_fork_reg.sv
// One-input, two-output registered fork; each branch drains on its own ready.
module sha256_fork_reg #(
  parameter int A_W = 8,
  parameter int B_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en_i,
  input  logic           clr_i,
  input  logic           load_i,
  input  logic [A_W-1:0] a_i,
  input  logic [B_W-1:0] b_i,
  input  logic           a_ready_i,
  input  logic           b_ready_i,
  output logic           a_valid_o,
  output logic           b_valid_o,
  output logic [A_W-1:0] a_o,
  output logic [B_W-1:0] b_o
);
  logic           a_valid_q, b_valid_q;
  logic [A_W-1:0] a_q;
  logic [B_W-1:0] b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
    end else if (en_i) begin
      if (clr_i) begin
        a_valid_q <= 1'b0;
        b_valid_q <= 1'b0;
        a_q       <= '0;
        b_q       <= '0;
      end else if (load_i) begin
        // load only happens when both branches are empty or draining
        a_valid_q <= 1'b1;
        b_valid_q <= 1'b1;
        a_q       <= a_i;
        b_q       <= b_i;
      end else begin
        if (a_ready_i) a_valid_q <= 1'b0;
        if (b_ready_i) b_valid_q <= 1'b0;
      end
    end
  end

  assign a_valid_o = a_valid_q;
  assign b_valid_o = b_valid_q;
  assign a_o       = a_q;
  assign b_o       = b_q;
endmodule

// File: rtl/sha256_id_issue.sv
// Tags each configuration beat with a sequential ID, forks it to the message
// builder and the ID buffer, and caps in-flight IDs at the buffer depth.
module sha256_id_issue
  import sha256_pkg::*;
(
  input  logic                clk,
  input  logic                nrst,
  input  logic                en,
  input  logic                sync_rst,
  input  logic                id_retire,
  sha256_id_issue_if.slave    bus,
  output id_t                 status_id,
  output logic [3:0]          status_outstanding,
  output logic                status_err
);
  localparam int CFG_W = $bits(cfg_t) + ID_W;
  localparam int IDB_W = ID_W + 1;

  id_t        next_id_q, status_id_q;
  logic [3:0] outst_q;
  logic       err_q;

  logic             cfg_v, id_v, acc, clr;
  cfg_t             cfg_in, cfg_out;
  logic [CFG_W-1:0] cfg_pl, cfg_q;
  logic [IDB_W-1:0] id_pl, id_q;

  assign clr = en & sync_rst;

  // sync_rst blocks acceptance so a beat is never taken and then dropped
  assign bus.cfg_in_ready = en & ~sync_rst
                          & (outst_q < 4'(MAX_OUTSTANDING))
                          & (~cfg_v | bus.cfg_out_ready)
                          & (~id_v  | bus.id_out_ready);
  assign acc = bus.cfg_in_valid & bus.cfg_in_ready;

  assign cfg_in.size   = bus.cfg_in_size;
  assign cfg_in.scheme = bus.cfg_in_scheme;
  assign cfg_in.last   = bus.cfg_in_last;
  assign cfg_pl        = {cfg_in, next_id_q};
  assign id_pl         = {next_id_q, bus.cfg_in_last};

  sha256_fork_reg #(.A_W(CFG_W), .B_W(IDB_W)) u_fork (
    .clk       (clk),
    .rst_n     (nrst),
    .en_i      (en),
    .clr_i     (clr),
    .load_i    (acc),
    .a_i       (cfg_pl),
    .b_i       (id_pl),
    .a_ready_i (bus.cfg_out_ready),
    .b_ready_i (bus.id_out_ready),
    .a_valid_o (cfg_v),
    .b_valid_o (id_v),
    .a_o       (cfg_q),
    .b_o       (id_q)
  );

  assign {cfg_out, bus.cfg_out_id} = cfg_q;
  assign bus.cfg_out_size          = cfg_out.size;
  assign bus.cfg_out_scheme        = cfg_out.scheme;
  assign bus.cfg_out_last          = cfg_out.last;
  assign bus.cfg_out_valid         = cfg_v;
  assign {bus.id_out, bus.id_out_last} = id_q;
  assign bus.id_out_valid          = id_v;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      next_id_q   <= '0;
      status_id_q <= '0;
      outst_q     <= '0;
      err_q       <= 1'b0;
    end else if (clr) begin
      next_id_q   <= '0;
      status_id_q <= '0;
      outst_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      if (acc) begin
        next_id_q   <= next_id_q + 1'b1;
        status_id_q <= next_id_q;
      end
      // retire is honoured regardless of en
      if (acc && !id_retire) begin
        outst_q <= outst_q + 4'd1;
      end else if (!acc && id_retire) begin
        if (outst_q == 4'd0) err_q   <= 1'b1;
        else                 outst_q <= outst_q - 4'd1;
      end
    end
  end

  assign status_id          = status_id_q;
  assign status_outstanding = outst_q;
  assign status_err         = err_q;
endmodule

// File: tb/tb_sha256_id_issue.sv
// Scoreboard bench for sha256_id_issue with a transaction-level reference model.
module tb_sha256_id_issue;
  import sha256_pkg::*;

  logic clk = 1'b0;
  logic nrst, en, sync_rst, id_retire;
  id_t        status_id;
  logic [3:0] status_outstanding;
  logic       status_err;

  sha256_id_issue_if bus ();

  sha256_id_issue dut (
    .clk                (clk),
    .nrst               (nrst),
    .en                 (en),
    .sync_rst           (sync_rst),
    .id_retire          (id_retire),
    .bus                (bus.slave),
    .status_id          (status_id),
    .status_outstanding (status_outstanding),
    .status_err         (status_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] size;
    logic [1:0]  scheme;
    logic        last;
    int          id;
  } beat_t;

  beat_t cq[$];
  beat_t iq[$];

  int total = 0;
  int bad   = 0;

  // reference state: plain integers, not the RTL encoding
  int nid_m, sid_m, out_m;
  bit err_m, cv_m, iv_m;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit e, input bit v, input bit s, input bit r,
                       input bit cr, input bit ir);
    @(negedge clk);
    en                = e;
    bus.cfg_in_valid  = v;
    sync_rst          = s;
    id_retire         = r;
    bus.cfg_out_ready = cr;
    bus.id_out_ready  = ir;
    bus.cfg_in_size   = {$urandom, $urandom};
    bus.cfg_in_scheme = 2'($urandom);
    bus.cfg_in_last   = 1'($urandom);
  endtask

  // reference model: checks registered state, predicts ready, records accepted beats
  always begin
    bit    exp_rdy, acc;
    beat_t b;
    @(negedge clk);
    #3;
    if (!nrst) begin
      nid_m = 0; sid_m = 0; out_m = 0;
      err_m = 0; cv_m = 0; iv_m = 0;
      cq.delete(); iq.delete();
    end else begin
      chk("cfg_out_valid", 64'(bus.cfg_out_valid), 64'(cv_m));
      chk("id_out_valid",  64'(bus.id_out_valid),  64'(iv_m));
      chk("status_id",     64'(status_id),          64'(sid_m));
      chk("status_outstanding", 64'(status_outstanding), 64'(out_m));
      chk("status_err",    64'(status_err),         64'(err_m));
      exp_rdy = en && !sync_rst && (out_m < MAX_OUTSTANDING)
                && (!cv_m || bus.cfg_out_ready) && (!iv_m || bus.id_out_ready);
      chk("cfg_in_ready", 64'(bus.cfg_in_ready), 64'(exp_rdy));
      acc = exp_rdy && bus.cfg_in_valid;
      if (en && sync_rst) begin
        nid_m = 0; sid_m = 0; out_m = 0;
        err_m = 0; cv_m = 0; iv_m = 0;
        cq.delete(); iq.delete();
      end else begin
        if (acc) begin
          b.size = bus.cfg_in_size; b.scheme = bus.cfg_in_scheme;
          b.last = bus.cfg_in_last; b.id = nid_m;
          cq.push_back(b); iq.push_back(b);
          cv_m = 1; iv_m = 1;
          sid_m = nid_m;
          nid_m = (nid_m + 1) % (1 << ID_W);
        end else if (en) begin
          if (bus.cfg_out_ready) cv_m = 0;
          if (bus.id_out_ready)  iv_m = 0;
        end
        if (acc && !id_retire) out_m++;
        else if (!acc && id_retire) begin
          if (out_m == 0) err_m = 1;
          else out_m--;
        end
      end
    end
  end

  // monitor: pops expectations whenever an output completes a handshake
  always begin
    beat_t b;
    @(negedge clk);
    #3;
    if (nrst && en && !sync_rst) begin
      if (bus.cfg_out_valid && bus.cfg_out_ready) begin
        if (cq.size() == 0) begin
          chk("cfg_unexpected_beat", 64'd1, 64'd0);
        end else begin
          b = cq.pop_front();
          chk("cfg_out_size", bus.cfg_out_size, b.size);
          chk("cfg_out_tag", 64'({bus.cfg_out_scheme, bus.cfg_out_last, bus.cfg_out_id}),
              64'({b.scheme, b.last, 6'(b.id)}));
        end
      end
      if (bus.id_out_valid && bus.id_out_ready) begin
        if (iq.size() == 0) begin
          chk("id_unexpected_beat", 64'd1, 64'd0);
        end else begin
          b = iq.pop_front();
          chk("id_out", 64'({bus.id_out, bus.id_out_last}), 64'({6'(b.id), b.last}));
        end
      end
    end
  end

  initial begin
    nrst = 1'b0; en = 1'b0; sync_rst = 1'b0; id_retire = 1'b0;
    bus.cfg_in_valid = 1'b0; bus.cfg_in_size = '0; bus.cfg_in_scheme = '0;
    bus.cfg_in_last = 1'b0; bus.cfg_out_ready = 1'b0; bus.id_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cfg_in_ready",  64'(bus.cfg_in_ready),  64'd0);
    chk("rst_cfg_out_valid", 64'(bus.cfg_out_valid), 64'd0);
    chk("rst_id_out_valid",  64'(bus.id_out_valid),  64'd0);
    chk("rst_cfg_out_size",  bus.cfg_out_size,       64'd0);
    chk("rst_cfg_out_id",    64'(bus.cfg_out_id),    64'd0);
    chk("rst_id_out",        64'(bus.id_out),        64'd0);
    chk("rst_status_id",     64'(status_id),         64'd0);
    chk("rst_status_out",    64'(status_outstanding), 64'd0);
    chk("rst_status_err",    64'(status_err),        64'd0);
    nrst = 1'b1;

    // three beats, outputs always ready
    repeat (3) drive(1, 1, 0, 0, 1, 1);
    repeat (2) drive(1, 0, 0, 0, 1, 1);
    @(posedge clk); #1;
    chk("a_status_id",  64'(status_id), 64'd2);
    chk("a_status_out", 64'(status_outstanding), 64'd3);
    repeat (3) drive(1, 0, 0, 1, 1, 1);

    // full ID wrap with a retire after each beat
    drive(1, 0, 1, 0, 1, 1);
    for (int i = 0; i < 65; i++) begin
      drive(1, 1, 0, 0, 1, 1);
      drive(1, 0, 0, 1, 1, 1);
    end
    @(posedge clk); #1;
    chk("b_wrap_status_id", 64'(status_id), 64'd0);

    // fill to the outstanding limit, one retire lets exactly one more in
    drive(1, 0, 1, 0, 1, 1);
    repeat (10) drive(1, 1, 0, 0, 1, 1);
    @(posedge clk); #1;
    chk("c_full_out",   64'(status_outstanding), 64'd8);
    chk("c_full_ready", 64'(bus.cfg_in_ready),   64'd0);
    drive(1, 1, 0, 1, 1, 1);
    repeat (4) drive(1, 1, 0, 0, 1, 1);
    @(posedge clk); #1;
    chk("c_extra_id", 64'(status_id), 64'd8);
    repeat (9) drive(1, 0, 0, 1, 1, 1);
    drive(1, 0, 0, 1, 1, 1);
    @(posedge clk); #1;
    chk("c_err_set", 64'(status_err), 64'd1);
    chk("c_err_out", 64'(status_outstanding), 64'd0);

    // sync_rst while both slots hold a beat
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0);
    @(posedge clk); #1;
    chk("e_srst_cfg_valid", 64'(bus.cfg_out_valid), 64'd0);
    chk("e_srst_id_valid",  64'(bus.id_out_valid),  64'd0);
    chk("e_srst_err",       64'(status_err),        64'd0);
    drive(1, 1, 0, 0, 1, 1);
    drive(1, 0, 0, 1, 1, 1);

    // id_out stalled while config output drains; ID 5
    drive(1, 0, 1, 0, 1, 1);
    repeat (5) begin
      drive(1, 1, 0, 0, 1, 1);
      drive(1, 0, 0, 1, 1, 1);
    end
    drive(1, 1, 0, 0, 1, 0);
    repeat (4) begin
      drive(1, 1, 0, 0, 1, 0);
      chk("d_id_hold", 64'(bus.id_out), 64'd5);
    end
    drive(1, 0, 0, 0, 1, 1);
    repeat (2) drive(1, 0, 0, 1, 1, 1);

    // en low mid-stream
    repeat (3) drive(1, 1, 0, 0, 1, 1);
    repeat (4) drive(0, 1, 0, 0, 1, 1);
    repeat (3) drive(1, 1, 0, 0, 1, 1);
    repeat (6) drive(1, 0, 0, 1, 1, 1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 10) != 0, 1'($urandom), ($urandom % 50) == 0,
            ($urandom % 3) == 0, ($urandom % 4) != 0, ($urandom % 4) != 0);
    end
    repeat (5) drive(1, 0, 0, 0, 1, 1);
    @(posedge clk); #4;
    chk("end_cfg_queue_empty", 64'(cq.size()), 64'd0);
    chk("end_id_queue_empty",  64'(iq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
